// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply / divide engine for the multicycle core.
// A single 2*WIDTH-bit accumulator and one WIDTH+1-bit adder/subtractor are shared
// between shift-add multiplication and restoring division. Operands are reduced to
// magnitudes up front, and the signs are re-applied in a single fix-up cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_done,
  output logic             div_done,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;

  logic                     r_op_div;
  logic signed [WIDTH-1:0]  r_a;
  logic signed [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]         r_absb;
  logic                     r_sq;
  logic                     r_sr;
  logic                     r_dz;
  logic [2*WIDTH-1:0]       r_acc;
  logic [CW-1:0]            r_cnt;
  logic [WIDTH-1:0]         r_hi;
  logic [WIDTH-1:0]         r_lo;

  logic [2*WIDTH-1:0]       w_shl;
  logic [WIDTH:0]           w_opa;
  logic [WIDTH:0]           w_opb;
  logic                     w_cin;
  logic [WIDTH:0]           w_sum;

  // Magnitude of a signed operand; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Two's-complement negate when n is set.
  function automatic logic [WIDTH-1:0] neg_cond(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign w_shl = {r_acc[2*WIDTH-2:0], 1'b0};

  // Shared adder: multiply adds |b| to the upper half (carry kept in bit W);
  // divide subtracts |b| from the shifted remainder (bit W set means borrow).
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_cin = 1'b0;
    if (r_op_div) begin
      w_opa = {1'b0, w_shl[2*WIDTH-1:WIDTH]};
      w_opb = ~{1'b0, r_absb};
      w_cin = 1'b1;
    end else begin
      w_opa = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
      w_opb = r_acc[0] ? {1'b0, r_absb} : '0;
      w_cin = 1'b0;
    end
    w_sum = w_opa + w_opb + (WIDTH+1)'(w_cin);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; starts are only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (mult_start || div_start) w_next = PREP;
      PREP:    w_next = (r_op_div && (r_b == '0)) ? FIX : ITER;
      ITER:    if (r_cnt == CW'(1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_absb   <= '0;
      r_sq     <= 1'b0;
      r_sr     <= 1'b0;
      r_dz     <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (mult_start || div_start) begin
            r_op_div <= ~mult_start;
            r_a      <= a;
            r_b      <= b;
            r_dz     <= 1'b0;
          end
        end
        PREP: begin
          r_absb <= abs_val(r_b);
          r_sq   <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_sr   <= r_a[WIDTH-1];
          r_acc  <= {{WIDTH{1'b0}}, abs_val(r_a)};
          r_cnt  <= CW'(WIDTH);
          if (r_op_div && (r_b == '0)) r_dz <= 1'b1;
        end
        ITER: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_op_div) begin
            if (!w_sum[WIDTH]) r_acc <= {w_sum[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};
            else               r_acc <= w_shl;
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (r_dz) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else if (r_op_div) begin
            r_hi <= neg_cond(r_acc[2*WIDTH-1:WIDTH], r_sr);
            r_lo <= neg_cond(r_acc[WIDTH-1:0], r_sq);
          end else begin
            {r_hi, r_lo} <= r_sq ? -r_acc : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = (r_state != IDLE);
  assign mult_done = (r_state == DONE) && !r_op_div;
  assign div_done  = (r_state == DONE) && r_op_div;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer with a scoreboard queue.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         mult_start;
  logic         div_start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         mult_done;
  logic         div_done;
  logic         busy;
  logic         div_zero;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .mult_done  (mult_done),
    .div_done   (div_done),
    .busy       (busy),
    .div_zero   (div_zero)
  );

  typedef struct {
    bit           is_div;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           dz;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result computed with 64-bit signed arithmetic.
  function automatic exp_t model(input bit is_div, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.is_div = is_div;
    e.dz     = 1'b0;
    if (!is_div) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Issue one operation, follow it to its done pulse, and check everything on the way.
  task automatic run_op(input bit is_div, input bit both, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int exp_lat, input int pulse_cyc);
    exp_t         e;
    int           cyc;
    int           busy_bad;
    int           dual;
    bit           seen;
    bit           got_div;
    logic [W-1:0] hold_hi;
    logic [W-1:0] hold_lo;
    @(negedge clk);
    mult_start = !is_div || both;
    div_start  = is_div || both;
    a = x;
    b = y;
    sb_q.push_back(model(is_div && !both, x, y));
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    a = $urandom;
    b = $urandom;
    cyc      = 1;
    busy_bad = 0;
    dual     = 0;
    seen     = 1'b0;
    got_div  = 1'b0;
    check("dz_clear_on_start", W'(div_zero), '0);
    while (cyc <= 60) begin
      div_start = (cyc == pulse_cyc);
      if (busy !== 1'b1) busy_bad++;
      if (mult_done || div_done) begin
        seen    = 1'b1;
        got_div = div_done;
        if (mult_done && div_done) dual++;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    div_start = 1'b0;
    e = sb_q.pop_front();
    check("done_seen", W'(seen), W'(1));
    if (seen) begin
      check("latency", W'(cyc), W'(exp_lat));
      check("done_kind", W'(got_div), W'(e.is_div));
      check("hi", hi, e.hi);
      check("lo", lo, e.lo);
      check("div_zero", W'(div_zero), W'(e.dz));
    end
    check("busy_through_done", W'(busy_bad), '0);
    check("single_done", W'(dual), '0);
    // A start presented during the DONE cycle must be ignored.
    hold_hi    = hi;
    hold_lo    = lo;
    mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    check("idle_busy", W'(busy), '0);
    check("done_pulse_len", W'({mult_done, div_done}), '0);
    check("hi_hold", hi, hold_hi);
    check("lo_hold", lo, hold_lo);
  endtask

  initial begin
    int dones;
    int cyc;
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit d;

    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_done", W'({mult_done, div_done}), '0);
    check("rst_dz", W'(div_zero), '0);
    reset = 1'b0;

    run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 35, 0);
    check("mul_7x-3_hi", hi, 32'hFFFF_FFFF);
    check("mul_7x-3_lo", lo, 32'hFFFF_FFEB);

    run_op(1'b1, 1'b0, 32'hFFFF_FFEF, 32'd5, 35, 0);
    check("div_-17/5_lo", lo, 32'hFFFF_FFFD);
    check("div_-17/5_hi", hi, 32'hFFFF_FFFE);

    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 35, 0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 35, 0);
    check("mul_min_hi", hi, 32'h4000_0000);
    check("mul_min_lo", lo, 32'h0000_0000);

    run_op(1'b1, 1'b0, 32'd42, 32'd0, 3, 0);
    check("dz_held_in_idle", W'(div_zero), W'(1));
    check("dz_hi", hi, 32'd42);
    check("dz_lo", lo, 32'hFFFF_FFFF);

    run_op(1'b0, 1'b0, 32'd5, 32'd6, 35, 0);
    check("dz_cleared_after_mult", W'(div_zero), '0);

    // Both starts together, plus a stray div_start in cycle 10.
    run_op(1'b0, 1'b1, 32'd1234, 32'hFFFF_F000, 35, 10);
    repeat (40) begin
      @(negedge clk);
      dones += (mult_done || div_done) ? 1 : 0;
    end
    check("no_extra_done_after_both", W'(dones), '0);

    // Reset in cycle 20 of a multiply.
    @(negedge clk);
    mult_start = 1'b1;
    a = 32'd99;
    b = 32'd77;
    @(negedge clk);
    mult_start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", W'(busy), '0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    check("abort_done", W'({mult_done, div_done}), '0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      dones += (mult_done || div_done) ? 1 : 0;
    end
    check("abort_no_done", W'(dones), '0);
    run_op(1'b0, 1'b0, 32'd99, 32'd77, 35, 0);

    // Sign-combination corner cases for division.
    run_op(1'b1, 1'b0, 32'd17, 32'hFFFF_FFFB, 35, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFEF, 32'hFFFF_FFFB, 35, 0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, 35, 0);
    run_op(1'b1, 1'b0, 32'd0, 32'd7, 35, 0);
    run_op(1'b1, 1'b0, 32'd5, 32'h8000_0000, 35, 0);

    for (int i = 0; i < 8; i++) begin
      d = i[0];
      x = $urandom;
      y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      run_op(d, 1'b0, x, y, 35, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : init_counters
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative signed multiply/divide engine with its own sequencing FSM; serves the MULT and DIV instructions of the multicycle core.
- Control unit pulses mult_start/div_start with operands from regs A/B, then waits for mult_done/div_done. On the done cycle it writes hi/lo into the HI/LO registers.
- One shared 2*WIDTH-bit accumulator and adder/subtractor is time-multiplexed between both operations.

Parameters:
- WIDTH, 32, operand width; also the iteration count.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- mult_start  input  1  one-cycle request: signed a*b
- div_start  input  1  one-cycle request: signed a/b
- a  input  WIDTH  multiplicand / dividend; sampled only on the accepted start cycle
- b  input  WIDTH  multiplier / divisor; sampled only on the accepted start cycle
- hi  output  WIDTH  mult: product[2W-1:W]; div: remainder
- lo  output  WIDTH  mult: product[W-1:0]; div: quotient
- mult_done  output  1  one-cycle pulse; hi/lo valid
- div_done  output  1  one-cycle pulse; hi/lo valid
- busy  output  1  high from the cycle after acceptance through the done cycle inclusive
- div_zero  output  1  registered; set on a divide with b==0, cleared on next accepted start

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE; hi=0, lo=0, mult_done=0, div_done=0, busy=0, div_zero=0; accumulator and counter are 0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - mult_start=1 → latch a,b, op=MUL → PREP.
  - Else div_start=1 → latch a,b, op=DIV → PREP.
  - Both high: mult wins; div_start is dropped, not queued.
- PREP (1 cycle):
  - Store |a|, |b| as unsigned WIDTH bits (|-2^(W-1)| = 2^(W-1) unsigned).
  - Store result signs: sq = a[W-1]^b[W-1]; sr = a[W-1].
  - Clear accumulator; counter = WIDTH.
  - DIV with b==0 → set div_zero and go to FIX, skipping ITER.
- ITER (exactly WIDTH cycles; counter decrements each cycle; leave when counter reaches 1→0):
  - MUL, shift-add: if acc[0], add |b| to acc[2W-1:W] with carry kept; then shift acc right 1.
  - DIV, restoring: shift {rem,quot} left 1; trial = rem-|b|; if trial ≥ 0, rem=trial and quot[0]=1.
- FIX (1 cycle):
  - MUL: negate the 2W-bit product if sq.
  - DIV: quotient negated if sq; remainder negated if sr (truncate toward zero; remainder takes the dividend's sign).
  - div_zero: hi=a, lo={W{1}}.
  - Load hi/lo registers.
- DONE (1 cycle): assert mult_done or div_done per op → IDLE.
- Latency: start accepted at edge 0 → done high in cycle WIDTH+3 (35 for W=32). A divide by zero completes in cycle 3.
- hi/lo hold their value from DONE until the FIX of the next operation; they are not cleared between operations.
- Overflow: -2^31 / -1 → lo=0x80000000, hi=0, no flag.
- Starts while busy: ignored, no effect on the operation in flight; the requester must wait for done.
- Start in the DONE cycle: ignored; a start is accepted only in IDLE.
- Reset mid-operation: abort to IDLE next edge, all outputs to reset values, no done pulse.
- Only one of mult_done/div_done is high at a time.

Test Plan:
- mult_start, a=7, b=-3 → mult_done in cycle 35 after acceptance; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1–35.
- div_start, a=-17, b=5 → div_done in cycle 35; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2).
- div_start, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Then mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- div_start, a=42, b=0 → div_done in cycle 3, div_zero=1, hi=42, lo=0xFFFFFFFF. Next mult_start clears div_zero.
- mult_start and div_start asserted together; then div_start pulsed at cycle 10 → only one mult_done and no div_done; result is a*b from the start cycle.
- reset asserted at cycle 20 of a multiply → next cycle IDLE with busy=0 and hi=lo=0; no done pulse. A new mult then completes normally.
